rr_mux: RTL and testbench
=========================

RR_MUX -- requirements
Module: rr_mux

Interface
REQ-001 Parameter W, default 4: data width per channel in bits.
REQ-002 Parameter CH, default 4: number of input channels, legal range 2..16.
REQ-003 Parameter MODE, default 1: 0 = fixed select via sel; 1 = round-robin arbitration.
REQ-004 Parameter SW, default $clog2(CH): width of the sel and out_ch fields, derived, not overridden.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 in_data  in  CH*W  channel k occupies bits [k*W +: W].
REQ-009 in_valid  in  CH  channel k offers a word.
REQ-010 in_ready  out  CH  channel k word accepted this cycle.
REQ-011 sel  in  SW  selected channel, MODE=0 only, ignored in MODE=1.
REQ-012 out_data  out  W  registered output word.
REQ-013 out_valid  out  1  out_data holds an unconsumed word.
REQ-014 out_ready  in  1  downstream consumes the word.
REQ-015 out_ch  out  SW  source channel index of out_data.

Function
REQ-016 A transfer on channel k SHALL occur when in_valid[k] && in_ready[k]; output transfer when out_valid && out_ready.
REQ-017 The output stage SHALL be one register deep; slot free = !out_valid || out_ready.
REQ-018 At most one in_ready bit SHALL be high per cycle, only for the granted channel, only when the slot is free.
REQ-019 in_ready SHALL be combinational from in_valid, sel, pointer, out_valid and out_ready, never from in_data.
REQ-020 Latency: an accepted word SHALL appear on out_data/out_valid the next cycle, with out_ch = its channel.
REQ-021 Simultaneous output drain and input accept SHALL give full throughput: one word per cycle, out_valid stays 1.
REQ-022 Drain with no accept SHALL clear out_valid next cycle; out_data/out_ch hold their last value.
REQ-023 While out_valid && !out_ready, out_data and out_ch SHALL remain stable.
REQ-024 MODE=0: grant = sel if in_valid[sel]; if sel >= CH there SHALL be no grant. Out of range is never high-impedance.
REQ-025 MODE=1: a pointer ptr (SW bits) SHALL name the highest-priority channel. Grant = first k with in_valid[k], searching ptr, ptr+1, ... modulo CH.
REQ-026 MODE=1: after a transfer from channel g, ptr SHALL become g+1, wrapping CH-1 -> 0. Without a transfer, ptr holds.
REQ-027 Non-power-of-two CH SHALL wrap at CH, never at 2^SW.
REQ-028 No valid input: no in_ready high, ptr holds.
REQ-029 The grant SHALL be re-evaluated every cycle. A stalled requester may lose to a higher-priority one; no input is stored internally.

Reset
REQ-030 While rst_n=0, outputs SHALL be: out_valid=0, out_data=0, out_ch=0, ptr=0, all in_ready=0.
REQ-031 Reset asserted mid-transfer SHALL discard the held word, with no later replay.
REQ-032 The first acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-033 Package rr_mux_pkg SHALL hold the MODE encodings (MODE_FIXED=0, MODE_RR=1) and a function computing channel index width.
REQ-034 Sub-module rr_arbiter (CH-wide request vector, ptr in, one-hot grant and encoded index out, combinational) SHALL contain the priority search.
REQ-035 rr_mux SHALL instantiate rr_arbiter, contain the ptr register and output register, and handle the MODE=0 path inline.

Verification
REQ-036 Reset: hold rst_n=0 with all in_valid=1 -> out_valid=0, in_ready=0, out_ch=0. Release -> channel 0 word appears 1 cycle later.
REQ-037 MODE=1, CH=4, all in_valid=1, out_ready=1, data k=0xk -> out_ch sequence 0,1,2,3,0 on consecutive cycles, out_valid continuous.
REQ-038 MODE=1, out_ready=0 for 3 cycles with a word held -> out_data/out_ch stable, in_ready=0. out_ready=1 -> drain plus new accept in the same cycle.
REQ-039 MODE=0, CH=3, sel=2, in_valid=3'b100, in_data ch2=0x9 -> out_data=0x9, out_ch=2. sel=3 -> no in_ready, out_valid falls after drain.
REQ-040 MODE=1, CH=3, only ch2 valid then only ch0 valid -> ptr wraps 2 -> 0, grant ch0 next.
REQ-041 rst_n pulsed low while out_valid=1 -> out_valid=0 immediately (asynchronous), no stale word emitted after release.

Source files
------------

// File: rtl/rr_mux_pkg.sv
// Shared encodings and helpers for the round-robin / fixed-select channel mux.
package rr_mux_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    // Channel index width; never narrower than one bit so CH=2 still gets a real field.
    function automatic int chan_idx_w(input int ch);
        return (ch <= 2) ? 1 : $clog2(ch);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority search: first requester at or after ptr, wrapping at CH.
// Purely combinational; one-hot grant plus encoded index.
module rr_arbiter #(
    parameter int CH = 4,
    parameter int SW = 2
) (
    input  logic [CH-1:0] req,
    input  logic [SW-1:0] ptr,
    output logic [CH-1:0] gnt,
    output logic [SW-1:0] gnt_idx
);

    // One spare bit so ptr+i cannot overflow before the modulo-CH correction.
    logic [SW:0] cand;
    logic        found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int i = 0; i < CH; i++) begin
            cand = {1'b0, ptr} + (SW+1)'(i);
            if (cand >= (SW+1)'(CH)) begin
                cand = cand - (SW+1)'(CH);
            end
            if (!found && req[cand[SW-1:0]]) begin
                found                = 1'b1;
                gnt[cand[SW-1:0]]    = 1'b1;
                gnt_idx              = cand[SW-1:0];
            end
        end
    end

endmodule

// File: rtl/rr_mux.sv
// CH-to-1 channel mux into a single output register; round-robin or sel-driven grant.
// One cycle accept-to-output; in_ready only when the output slot is empty or draining.
module rr_mux
    import rr_mux_pkg::*;
#(
    parameter int W    = 4,
    parameter int CH   = 4,
    parameter int MODE = MODE_RR,
    parameter int SW   = chan_idx_w(CH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [CH*W-1:0] in_data,
    input  logic [CH-1:0]   in_valid,
    output logic [CH-1:0]   in_ready,
    input  logic [SW-1:0]   sel,
    output logic [W-1:0]    out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SW-1:0]   out_ch
);

    logic [CH-1:0] fix_gnt;
    logic [CH-1:0] rr_gnt;
    logic [CH-1:0] gnt;
    logic [SW-1:0] rr_idx;
    logic [SW-1:0] gnt_idx;
    logic          slot_free;
    logic          accept;

    logic [SW-1:0] ptr_q,       ptr_d;
    logic [W-1:0]  out_data_q,  out_data_d;
    logic [SW-1:0] out_ch_q,    out_ch_d;
    logic          out_valid_q, out_valid_d;

    rr_arbiter #(
        .CH (CH),
        .SW (SW)
    ) u_arb (
        .req     (in_valid),
        .ptr     (ptr_q),
        .gnt     (rr_gnt),
        .gnt_idx (rr_idx)
    );

    // Fixed-select grant: an out-of-range sel matches no channel, so nothing is granted.
    always_comb begin
        fix_gnt = '0;
        for (int k = 0; k < CH; k++) begin
            if (sel == SW'(k)) begin
                fix_gnt[k] = in_valid[k];
            end
        end
    end

    assign gnt       = (MODE == MODE_RR) ? rr_gnt : fix_gnt;
    assign gnt_idx   = (MODE == MODE_RR) ? rr_idx : sel;
    assign slot_free = !out_valid_q || out_ready;
    // rst_n gates the handshake so no channel sees a grant while the block is held in reset.
    assign in_ready  = (rst_n && slot_free) ? gnt : '0;
    assign accept    = |in_ready;

    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        for (int k = 0; k < CH; k++) begin
            if (in_ready[k]) begin
                out_data_d = in_data[k*W +: W];
            end
        end
        if (accept) begin
            out_ch_d    = gnt_idx;
            out_valid_d = 1'b1;
            if (MODE == MODE_RR) begin
                ptr_d = (gnt_idx == SW'(CH-1)) ? '0 : gnt_idx + 1'b1;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_mux.sv
// Scoreboarded bench for rr_mux: RR CH=4, fixed-select CH=3 and RR CH=3 instances.
module tb_rr_mux;

    typedef struct {
        logic [3:0] ch;
        logic [3:0] data;
    } exp_t;

    logic clk;
    logic rst_n;

    // Instance a: MODE=1, CH=4
    logic [15:0] a_in_data;
    logic [3:0]  a_in_valid, a_in_ready;
    logic [1:0]  a_sel, a_out_ch;
    logic [3:0]  a_out_data;
    logic        a_out_valid, a_out_ready;

    // Instance f: MODE=0, CH=3
    logic [11:0] f_in_data;
    logic [2:0]  f_in_valid, f_in_ready;
    logic [1:0]  f_sel, f_out_ch;
    logic [3:0]  f_out_data;
    logic        f_out_valid, f_out_ready;

    // Instance b: MODE=1, CH=3
    logic [11:0] b_in_data;
    logic [2:0]  b_in_valid, b_in_ready;
    logic [1:0]  b_sel, b_out_ch;
    logic [3:0]  b_out_data;
    logic        b_out_valid, b_out_ready;

    exp_t qa[$];
    exp_t qf[$];
    exp_t qb[$];

    int vectors    = 0;
    int miscompares = 0;

    rr_mux #(.W(4), .CH(4), .MODE(1)) u_a (
        .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .sel(a_sel), .out_data(a_out_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ch(a_out_ch)
    );

    rr_mux #(.W(4), .CH(3), .MODE(0)) u_f (
        .clk(clk), .rst_n(rst_n), .in_data(f_in_data), .in_valid(f_in_valid),
        .in_ready(f_in_ready), .sel(f_sel), .out_data(f_out_data),
        .out_valid(f_out_valid), .out_ready(f_out_ready), .out_ch(f_out_ch)
    );

    rr_mux #(.W(4), .CH(3), .MODE(1)) u_b (
        .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .sel(b_sel), .out_data(b_out_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ch(b_out_ch)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Output monitors: every output transfer must match the head of its scoreboard.
    always @(negedge clk) begin
        if (a_out_valid && a_out_ready) begin
            vectors++;
            if (qa.size() == 0) begin
                miscompares++;
                $display("FAIL a_unexpected_word: got ch=%0d data=%h, required no word", a_out_ch, a_out_data);
            end else begin
                exp_t e;
                e = qa.pop_front();
                if ({2'b00, a_out_ch} !== e.ch || a_out_data !== e.data) begin
                    miscompares++;
                    $display("FAIL a_word: got ch=%0d data=%h, required ch=%0d data=%h",
                             a_out_ch, a_out_data, e.ch, e.data);
                end
            end
        end
        if (f_out_valid && f_out_ready) begin
            vectors++;
            if (qf.size() == 0) begin
                miscompares++;
                $display("FAIL f_unexpected_word: got ch=%0d data=%h, required no word", f_out_ch, f_out_data);
            end else begin
                exp_t e;
                e = qf.pop_front();
                if ({2'b00, f_out_ch} !== e.ch || f_out_data !== e.data) begin
                    miscompares++;
                    $display("FAIL f_word: got ch=%0d data=%h, required ch=%0d data=%h",
                             f_out_ch, f_out_data, e.ch, e.data);
                end
            end
        end
        if (b_out_valid && b_out_ready) begin
            vectors++;
            if (qb.size() == 0) begin
                miscompares++;
                $display("FAIL b_unexpected_word: got ch=%0d data=%h, required no word", b_out_ch, b_out_data);
            end else begin
                exp_t e;
                e = qb.pop_front();
                if ({2'b00, b_out_ch} !== e.ch || b_out_data !== e.data) begin
                    miscompares++;
                    $display("FAIL b_word: got ch=%0d data=%h, required ch=%0d data=%h",
                             b_out_ch, b_out_data, e.ch, e.data);
                end
            end
        end
    end

    function automatic exp_t mk(input int ch, input int data);
        exp_t e;
        e.ch   = 4'(ch);
        e.data = 4'(data);
        return e;
    endfunction

    task automatic clear_inputs();
        a_in_data = '0; a_in_valid = '0; a_sel = '0; a_out_ready = 1'b0;
        f_in_data = '0; f_in_valid = '0; f_sel = '0; f_out_ready = 1'b0;
        b_in_data = '0; b_in_valid = '0; b_sel = '0; b_out_ready = 1'b0;
    endtask

    // Ends just after a rising edge with rst_n released.
    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        qa.delete(); qf.delete(); qb.delete();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        a_in_valid  = 4'b1111;
        a_in_data   = {4'h8, 4'h7, 4'h6, 4'h5};
        a_out_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 4'b0000 || a_out_ch !== 2'd0 || a_out_data !== 4'h0) begin
            miscompares++;
            $display("FAIL reset_state: got valid=%b ready=%b ch=%0d data=%h, required 0 0000 0 0",
                     a_out_valid, a_in_ready, a_out_ch, a_out_data);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        qa.push_back(mk(0, 5));
        @(negedge clk);
        vectors++;
        if (a_in_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL reset_first_ready: got %b, required 0001", a_in_ready);
        end
        @(posedge clk);
        #1 a_in_valid = '0;
        @(negedge clk);
        vectors++;
        if (a_out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_first_word: got valid=%b, required 1", a_out_valid);
        end
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (a_out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_drain: got valid=%b, required 0", a_out_valid);
        end
    endtask

    task automatic test_rr_sequence();
        int seq[5] = '{0, 1, 2, 3, 0};
        do_reset();
        a_in_data   = {4'h3, 4'h2, 4'h1, 4'h0};
        a_in_valid  = 4'b1111;
        a_out_ready = 1'b1;
        for (int i = 0; i < 5; i++) qa.push_back(mk(seq[i], seq[i]));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1 if (i == 4) a_in_valid = '0;
            @(negedge clk);
            vectors++;
            if (a_out_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL rr_continuous[%0d]: got valid=%b, required 1", i, a_out_valid);
            end
        end
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (a_out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rr_tail_drain: got valid=%b, required 0", a_out_valid);
        end
    endtask

    task automatic test_stall();
        do_reset();
        a_in_data   = {4'hB, 4'hA, 4'h9, 4'h8};
        a_in_valid  = 4'b1111;
        a_out_ready = 1'b0;
        qa.push_back(mk(0, 8));
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (a_out_valid !== 1'b1 || a_out_data !== 4'h8 || a_out_ch !== 2'd0 || a_in_ready !== 4'b0000) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: got valid=%b data=%h ch=%0d ready=%b, required 1 8 0 0000",
                         i, a_out_valid, a_out_data, a_out_ch, a_in_ready);
            end
            @(posedge clk);
            #1;
        end
        a_out_ready = 1'b1;
        qa.push_back(mk(1, 9));
        @(negedge clk);
        vectors++;
        if (a_in_ready !== 4'b0010) begin
            miscompares++;
            $display("FAIL stall_release_ready: got %b, required 0010", a_in_ready);
        end
        @(posedge clk);
        #1 a_in_valid = '0;
        @(negedge clk);
        vectors++;
        if (a_out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_refill: got valid=%b, required 1", a_out_valid);
        end
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (a_out_valid !== 1'b0 || a_out_data !== 4'h9 || a_out_ch !== 2'd1) begin
            miscompares++;
            $display("FAIL stall_drain_hold: got valid=%b data=%h ch=%0d, required 0 9 1",
                     a_out_valid, a_out_data, a_out_ch);
        end
    endtask

    task automatic test_fixed();
        do_reset();
        f_in_data   = {4'h9, 4'h5, 4'h4};
        f_in_valid  = 3'b100;
        f_sel       = 2'd2;
        f_out_ready = 1'b1;
        qf.push_back(mk(2, 9));
        @(negedge clk);
        vectors++;
        if (f_in_ready !== 3'b100) begin
            miscompares++;
            $display("FAIL fixed_sel2_ready: got %b, required 100", f_in_ready);
        end
        @(posedge clk);
        #1 f_sel = 2'd3;
        @(negedge clk);
        vectors++;
        if (f_in_ready !== 3'b000 || f_out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL fixed_sel3: got ready=%b valid=%b, required 000 1", f_in_ready, f_out_valid);
        end
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (f_out_valid !== 1'b0 || f_in_ready !== 3'b000) begin
            miscompares++;
            $display("FAIL fixed_sel3_drain: got valid=%b ready=%b, required 0 000", f_out_valid, f_in_ready);
        end
        f_sel      = 2'd1;
        f_in_valid = 3'b011;
        qf.push_back(mk(1, 5));
        #1;
        vectors++;
        if (f_in_ready !== 3'b010) begin
            miscompares++;
            $display("FAIL fixed_sel1_ready: got %b, required 010", f_in_ready);
        end
        @(posedge clk);
        #1 f_in_valid = '0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_wrap();
        logic [2:0] pat[4]  = '{3'b100, 3'b001, 3'b101, 3'b011};
        logic [2:0] rdy[4]  = '{3'b100, 3'b001, 3'b100, 3'b001};
        int         ch[4]   = '{2, 0, 2, 0};
        int         dat[4]  = '{9, 4, 9, 4};
        do_reset();
        b_in_data   = {4'h9, 4'h5, 4'h4};
        b_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b_in_valid = pat[i];
            qb.push_back(mk(ch[i], dat[i]));
            @(negedge clk);
            vectors++;
            if (b_in_ready !== rdy[i]) begin
                miscompares++;
                $display("FAIL wrap_ready[%0d]: got %b, required %b", i, b_in_ready, rdy[i]);
            end
            @(posedge clk);
            #1;
        end
        b_in_valid = '0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        do_reset();
        a_in_data   = {4'h0, 4'h0, 4'h0, 4'hC};
        a_in_valid  = 4'b0001;
        a_out_ready = 1'b0;
        qa.push_back(mk(0, 12));
        @(posedge clk);
        #1 a_in_valid = '0;
        @(negedge clk);
        vectors++;
        if (a_out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL async_held: got valid=%b, required 1", a_out_valid);
        end
        #2 rst_n = 1'b0;
        qa.delete();
        #1;
        vectors++;
        if (a_out_valid !== 1'b0 || a_out_data !== 4'h0) begin
            miscompares++;
            $display("FAIL async_clear: got valid=%b data=%h, required 0 0", a_out_valid, a_out_data);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        a_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (a_out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL async_no_replay[%0d]: got valid=%b, required 0", i, a_out_valid);
            end
        end
    endtask

    task automatic test_scoreboard_empty();
        vectors++;
        if (qa.size() != 0 || qf.size() != 0 || qb.size() != 0) begin
            miscompares++;
            $display("FAIL missing_words: got pending a=%0d f=%0d b=%0d, required 0 0 0",
                     qa.size(), qf.size(), qb.size());
        end
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_scoreboard_empty();
        test_rr_sequence();
        test_scoreboard_empty();
        test_stall();
        test_scoreboard_empty();
        test_fixed();
        test_scoreboard_empty();
        test_wrap();
        test_scoreboard_empty();
        test_async_reset();
        test_scoreboard_empty();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
